// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared types and encodings for the multicycle MIPS control FSM.
//   state_t : 4-bit FSM state encoding (also exported on main_control.state_o)
//   OP_*    : instruction[31:26] opcodes recognised in DECODE
//   SRCB_*, ALUOP_*, PCSRC_* : datapath mux / ALU control encodings
//   ctrl_t  : control word produced by ctrl_out_decode
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_RTYPEEX = 4'd7,
        ST_RTYPEWB = 4'd8,
        ST_BEQEX   = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] SRCB_REG     = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_IMM     = 3'b010;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       branch;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode -- Moore output decode for main_control.
//   state   : current FSM state
//   mem_go  : effective memory-ready (already forced to 1 when the handshake is disabled)
//   ctrl    : datapath control word; zero for any state not listed
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_go,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                // IR/PC only update on the cycle the fetch actually completes
                ctrl.ir_write = mem_go;
                ctrl.pc_write = mem_go;
            end
            ST_DECODE:  ctrl.alusrcb = SRCB_IMM_SH2;
            ST_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.mem_req = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.memtoreg  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.mem_req   = 1'b1;
            end
            ST_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_RTYPEWB: begin
                ctrl.regdst    = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ST_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ST_ADDIWB:  ctrl.reg_write = 1'b1;
            ST_JEX: begin
                ctrl.pcsrc    = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control.sv
// main_control -- multicycle MIPS control FSM (Moore).
//   clk, rst_n        : clock, async active-low reset
//   opcode            : instruction[31:26], looked at only in DECODE and MEMADR
//   mem_ready         : memory completes the current access this cycle
//   mem_req .. PCSrc  : datapath controls decoded from the state register
//   illegal_op        : one-cycle registered pulse after DECODE saw an unknown opcode
//   state_o           : current state encoding
// Build option: MEM_HANDSHAKE_EN -- when defined, FETCH/MEMRD/MEMWR wait on
// mem_ready; when undefined, mem_ready is ignored and every memory state lasts one cycle.
module main_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       Branch,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state;
    logic   run;        // set on the first edge after reset release; IDLE waits for it
    logic   illegal_q;
    logic   mem_go;
    ctrl_t  ctrl;

`ifdef MEM_HANDSHAKE_EN
    assign mem_go = mem_ready;
`else
    // Port kept so both builds share one interface; its value does not matter here.
    assign mem_go = mem_ready | 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            run       <= 1'b1;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE:   if (run) state <= ST_FETCH;
                ST_FETCH:  if (mem_go) state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= ST_MEMADR;
                        OP_RTYPE:     state <= ST_RTYPEEX;
                        OP_BEQ:       state <= ST_BEQEX;
                        OP_ADDI:      state <= ST_ADDIEX;
                        OP_J:         state <= ST_JEX;
                        default: begin
                            state     <= ST_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                ST_MEMADR:  state <= (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:   if (mem_go) state <= ST_MEMWB;
                ST_MEMWR:   if (mem_go) state <= ST_FETCH;
                ST_RTYPEEX: state <= ST_RTYPEWB;
                ST_ADDIEX:  state <= ST_ADDIWB;
                // MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX, and unused encodings
                default:    state <= ST_FETCH;
            endcase
        end
    end

    ctrl_out_decode u_dec (
        .state  (state),
        .mem_go (mem_go),
        .ctrl   (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign PCWrite    = ctrl.pc_write;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegWrite   = ctrl.reg_write;
    assign IorD       = ctrl.iord;
    assign MemtoReg   = ctrl.memtoreg;
    assign RegDst     = ctrl.regdst;
    assign Branch     = ctrl.branch;
    assign ALUSrcA    = ctrl.alusrca;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ALUOp      = ctrl.aluop;
    assign PCSrc      = ctrl.pcsrc;
    assign illegal_op = illegal_q;
    assign state_o    = state;

endmodule

// File: tb/tb_main_control.sv
// tb_main_control -- self-checking bench for main_control.
// Each instruction is modelled as the list of states it must visit; memory
// states repeat while mem_ready is low (handshake build only). Every cycle the
// state and full control vector are compared against the table of per-state outputs.
module tb_main_control;
    import mips_ctrl_pkg::*;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    logic       clk, rst_n, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, PCWrite, MemWrite, IRWrite, RegWrite, IorD, MemtoReg;
    logic       RegDst, Branch, ALUSrcA, illegal_op;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp, PCSrc;
    logic [3:0] state_o;
    logic [17:0] outs;

    int  nchk = 0;
    int  nerr = 0;
    bit  exp_ill = 1'b0;

    main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .Branch(Branch), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .illegal_op(illegal_op), .state_o(state_o)
    );

    assign outs = {mem_req, PCWrite, MemWrite, IRWrite, RegWrite, IorD, MemtoReg,
                   RegDst, Branch, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Required outputs for one state, straight from the per-state output table.
    function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr, input bit ill);
        logic mq, pcw, mw, irw, rw, iod, m2r, rd, br, sa;
        logic [2:0] sb;
        logic [1:0] op, pcs;
        logic fg;
        {mq, pcw, mw, irw, rw, iod, m2r, rd, br, sa} = '0;
        sb = 3'b000; op = 2'b00; pcs = 2'b00;
        fg = HS ? mr : 1'b1;
        case (s)
            ST_FETCH:   begin sb = 3'b001; mq = 1; irw = fg; pcw = fg; end
            ST_DECODE:  sb = 3'b011;
            ST_MEMADR:  begin sa = 1; sb = 3'b010; end
            ST_MEMRD:   begin iod = 1; mq = 1; end
            ST_MEMWB:   begin m2r = 1; rw = 1; end
            ST_MEMWR:   begin iod = 1; mw = 1; mq = 1; end
            ST_RTYPEEX: begin sa = 1; sb = 3'b000; op = 2'b10; end
            ST_RTYPEWB: begin rd = 1; rw = 1; end
            ST_BEQEX:   begin sa = 1; op = 2'b01; pcs = 2'b01; br = 1; end
            ST_ADDIEX:  begin sa = 1; sb = 3'b010; end
            ST_ADDIWB:  rw = 1;
            ST_JEX:     begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mq, pcw, mw, irw, rw, iod, m2r, rd, br, sa, sb, op, pcs, ill};
    endfunction

    function automatic logic [5:0] op_of(input int kind);
        logic [5:0] o;
        case (kind)
            K_LW:   o = OP_LW;
            K_SW:   o = OP_SW;
            K_R:    o = OP_RTYPE;
            K_BEQ:  o = OP_BEQ;
            K_ADDI: o = OP_ADDI;
            K_J:    o = OP_J;
            default: begin
                do o = 6'($urandom);
                while (o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ ||
                       o == OP_ADDI || o == OP_J);
            end
        endcase
        return o;
    endfunction

    // Release reset on a falling edge; the first rising edge must leave the FSM in IDLE.
    task automatic rst_release();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_idle_state", 32'(state_o), 32'(ST_IDLE));
        chk("rel_idle_outs", 32'(outs), 32'd0);
    endtask

    // Run one instruction. stall_wr forces mem_ready low for that many MEMWR cycles,
    // tie_low holds mem_ready at 0 throughout, abort_at (>=0) pulls reset mid-cycle
    // on reaching that state.
    task automatic do_instr(input int kind, input logic [5:0] op, input int stall_wr,
                            input bit tie_low, input int abort_at);
        logic [3:0] q[$];
        logic [3:0] cur;
        logic mr;
        int stalls = 0;
        int wr_lo = 0;
        q.push_back(ST_FETCH);
        q.push_back(ST_DECODE);
        case (kind)
            K_LW:   begin q.push_back(ST_MEMADR); q.push_back(ST_MEMRD); q.push_back(ST_MEMWB); end
            K_SW:   begin q.push_back(ST_MEMADR); q.push_back(ST_MEMWR); end
            K_R:    begin q.push_back(ST_RTYPEEX); q.push_back(ST_RTYPEWB); end
            K_BEQ:  q.push_back(ST_BEQEX);
            K_ADDI: begin q.push_back(ST_ADDIEX); q.push_back(ST_ADDIWB); end
            K_J:    q.push_back(ST_JEX);
            default: ;
        endcase
        while (q.size() > 0) begin
            cur = q[0];
            @(negedge clk);
            opcode = (cur == ST_DECODE || cur == ST_MEMADR) ? op : 6'($urandom);
            if (tie_low)                                mr = 1'b0;
            else if (cur == ST_MEMWR && wr_lo < stall_wr) mr = 1'b0;
            else if (stalls >= 8)                       mr = 1'b1;
            else                                        mr = ($urandom_range(0, 3) != 0);
            mem_ready = mr;
            #1;
            chk("state", 32'(state_o), 32'(cur));
            chk("ctrl", 32'(outs), 32'(exp_ctrl(cur, mr, exp_ill)));
            exp_ill = (cur == ST_DECODE && kind == K_ILL);
            if (cur == ST_MEMWR && !mr) wr_lo++;
            if (abort_at >= 0 && int'(cur) == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_state", 32'(state_o), 32'(ST_IDLE));
                chk("abort_outs", 32'(outs), 32'd0);
                exp_ill = 1'b0;
                @(negedge clk);
                #1;
                chk("abort_hold_state", 32'(state_o), 32'(ST_IDLE));
                chk("abort_hold_outs", 32'(outs), 32'd0);
                rst_release();
                return;
            end
            if (HS && !mr && (cur == ST_FETCH || cur == ST_MEMRD || cur == ST_MEMWR))
                stalls++;
            else
                void'(q.pop_front());
        end
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        opcode    = 6'h3f;
        mem_ready = 1'b0;
        #2;
        chk("por_state", 32'(state_o), 32'(ST_IDLE));
        chk("por_outs", 32'(outs), 32'd0);
        repeat (2) @(negedge clk);
        opcode = OP_J; mem_ready = 1'b1;
        #1;
        chk("rst_held_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_held_outs", 32'(outs), 32'd0);
        rst_release();

        do_instr(K_LW,  OP_LW,  0, 1'b0, -1);
        do_instr(K_SW,  OP_SW,  3, 1'b0, -1);
        do_instr(K_BEQ, OP_BEQ, 0, 1'b0, -1);
        do_instr(K_ILL, 6'h3f,  0, 1'b0, -1);
        do_instr(K_J,   OP_J,   0, 1'b0, -1);
        do_instr(K_R,   OP_RTYPE, 0, 1'b0, int'(ST_RTYPEEX));
        do_instr(K_ADDI, OP_ADDI, 0, 1'b0, -1);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 6);
            do_instr(k, op_of(k), $urandom_range(0, 2), 1'b0, -1);
        end

        if (!HS) begin
            do_instr(K_LW, OP_LW, 0, 1'b1, -1);
            do_instr(K_SW, OP_SW, 0, 1'b1, -1);
        end

        // Finish with a reset in the middle of a store to catch lingering write enables.
        do_instr(K_SW, OP_SW, 0, 1'b0, int'(ST_MEMWR));
        do_instr(K_ADDI, OP_ADDI, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
